// File: rtl/uart_bridge_pkg.sv
// Shared types and widths for the UART-to-Avalon command bridge.
// Optional feature macro: UART_BRIDGE_READ_EN (enables the READ opcode path).
package uart_bridge_pkg;

  localparam int CMD_W  = 34;
  localparam int DATA_W = 32;

  // Two-bit command opcode carried in the top bits of each received word.
  typedef enum logic [1:0] {
    OP_SETADDR = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_CTRL    = 2'b11
  } opcode_t;

  // Bridge FSM states; the read-side states are only reachable when reads are built.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_START,
    S_TX_WAIT
  } state_t;

  // One received command word as laid out by uart_rx.
  typedef struct packed {
    opcode_t             op;
    logic [DATA_W-1:0]   payload;
  } cmd_t;

endpackage

// File: rtl/uart_avalon_bridge.sv
// UART command bridge: one-deep command buffer feeding an FSM that issues a
// single Avalon-MM transaction per command and returns read data to uart_tx.
// Optional feature macro: UART_BRIDGE_READ_EN. When undefined, READ is a
// no-op and avm_read, o_Tx_DV and o_Tx_Byte are tied low.
module uart_avalon_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit RST_HOLD = 1'b1
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [CMD_W-1:0]  i_Rx_Byte,
  output logic              o_Tx_DV,
  output logic [DATA_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              o_Cpu_Rst_n,
  output logic              o_Overrun
);

  state_t            state;
  logic              pend_valid;
  cmd_t              pend_word;
  logic [ADDR_W-1:0] addr;
  logic              pop;

  // The FSM consumes the buffered command whenever it is idle.
  assign pop = (state == S_IDLE) && pend_valid;

  // The address register already sits still for the whole request, so it
  // drives the bus directly.
  assign avm_address    = addr;
  assign avm_byteenable = 4'hF;

`ifndef UART_BRIDGE_READ_EN
  assign avm_read  = 1'b0;
  assign o_Tx_DV   = 1'b0;
  assign o_Tx_Byte = '0;

  // Read-return inputs have no consumer in this build.
  logic unused_rd;
  assign unused_rd = ^{i_Tx_Done, avm_readdata, avm_readdatavalid};
`endif

  // Command holding register: accept a new word unless one is still waiting
  // and is not being popped this cycle; otherwise drop it and flag overrun.
  // NOTE: all clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      o_Overrun  <= 1'b0;
    end else if (i_Rx_DV) begin
      if (pend_valid && !pop) begin
        o_Overrun <= 1'b1;
      end else begin
        pend_valid <= 1'b1;
        pend_word  <= cmd_t'(i_Rx_Byte);
      end
    end else if (pop) begin
      pend_valid <= 1'b0;
    end
  end

  // Command FSM with registered bus, TX and core-reset outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      o_Cpu_Rst_n   <= ~RST_HOLD;
`ifdef UART_BRIDGE_READ_EN
      avm_read      <= 1'b0;
      o_Tx_DV       <= 1'b0;
      o_Tx_Byte     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_valid) begin
            case (pend_word.op)
              OP_SETADDR: addr <= ADDR_W'(pend_word.payload) & ~ADDR_W'(3);
              OP_WRITE: begin
                avm_write     <= 1'b1;
                avm_writedata <= pend_word.payload;
                state         <= S_WR;
              end
              OP_READ: begin
`ifdef UART_BRIDGE_READ_EN
                avm_read <= 1'b1;
                state    <= S_RD_REQ;
`endif
              end
              OP_CTRL: o_Cpu_Rst_n <= ~pend_word.payload[0];
            endcase
          end
        end
        S_WR: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            addr      <= addr + ADDR_W'(4);
            state     <= S_IDLE;
          end
        end
`ifdef UART_BRIDGE_READ_EN
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            o_Tx_Byte <= avm_readdata;
            state     <= S_TX_START;
          end
        end
        S_TX_START: begin
          o_Tx_DV <= 1'b1;
          state   <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          o_Tx_DV <= 1'b0;
          if (i_Tx_Done) begin
            addr  <= addr + ADDR_W'(4);
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_avalon_bridge.sv
// Self-checking bench for uart_avalon_bridge: a command table with expected
// bus transactions, plus hand sequences for overrun, read return and reset.
// Read checks follow UART_BRIDGE_READ_EN, matching the RTL build.
module tb_uart_avalon_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [33:0] rx_byte;
  logic        tx_dv;
  logic [31:0] tx_byte;
  logic        tx_done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        cpu_rst_n;
  logic        overrun;

  localparam logic [1:0] SETA = 2'b00, WR = 2'b01, RD = 2'b10, CTRL = 2'b11;

  uart_avalon_bridge #(.ADDR_W(32), .RST_HOLD(1'b1)) dut (
    .i_Clock           (clk),
    .i_Rst_n           (rst_n),
    .i_Rx_DV           (rx_dv),
    .i_Rx_Byte         (rx_byte),
    .o_Tx_DV           (tx_dv),
    .o_Tx_Byte         (tx_byte),
    .i_Tx_Done         (tx_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .o_Cpu_Rst_n       (cpu_rst_n),
    .o_Overrun         (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected bus transaction; hold = 0 leaves the request length unchecked.
  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } bus_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_tx[$];
  int          wr_count = 0;
  int          rd_count = 0;
  int          tx_count = 0;

  // Bus monitor: checks request stability and pops the scoreboard on accept.
  bit          in_req = 0;
  int          hold_cnt = 0;
  logic [31:0] cap_addr, cap_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_req = 0;
    end else if (avm_write || avm_read) begin
      check("rd_wr_exclusive", avm_read && avm_write, 1'b0);
      check("byteenable", avm_byteenable, 4'hF);
      if (!in_req) begin
        in_req   = 1;
        hold_cnt = 0;
        cap_addr = avm_address;
        cap_data = avm_writedata;
      end else begin
        check("addr_stable", avm_address, cap_addr);
        if (avm_write) check("data_stable", avm_writedata, cap_data);
      end
      hold_cnt++;
      if (!avm_waitrequest) begin
        bus_t e;
        in_req = 0;
        if (avm_write) wr_count++;
        else rd_count++;
        check("bus_expected", exp_bus.size() > 0, 1'b1);
        if (exp_bus.size() > 0) begin
          e = exp_bus.pop_front();
          check("bus_kind_rd", avm_read, e.is_rd);
          check("bus_addr", avm_address, e.addr);
          if (!e.is_rd) check("bus_wdata", avm_writedata, e.data);
          if (e.hold > 0) check("bus_hold", hold_cnt, e.hold);
        end
      end
    end
  end

  // TX monitor: every start strobe must match a queued read result.
  always @(negedge clk) begin
    if (rst_n && tx_dv) begin
      tx_count++;
      check("tx_expected", exp_tx.size() > 0, 1'b1);
      if (exp_tx.size() > 0) check("tx_byte", tx_byte, exp_tx.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] pl);
    rx_dv   = 1'b1;
    rx_byte = {op, pl};
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_bus(input string name);
    for (int i = 0; i < 40 && exp_bus.size() != 0; i++) tick();
    check(name, exp_bus.size(), 0);
    exp_bus.delete();
  endtask

  // Send one command, stall the first request for `waits` cycles, wait for
  // the scoreboard to drain.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] pl, input int waits);
    int cnt = 0;
    avm_waitrequest = (waits > 0);
    send(op, pl);
    for (int i = 0; i < 40 && exp_bus.size() != 0; i++) begin
      tick();
      if ((avm_write || avm_read) && avm_waitrequest) begin
        cnt++;
        if (cnt > waits) avm_waitrequest = 1'b0;
      end
    end
    check("cmd_drain", exp_bus.size(), 0);
    exp_bus.delete();
    avm_waitrequest = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] payload;
    int          waits;
    bit          exp_wr;
    logic [31:0] exp_addr;
    logic        exp_cpu;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int wr_before, tx_before;

    rst_n = 1'b0;
    rx_dv = 1'b0;
    rx_byte = '0;
    tx_done = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;

    vecs[0]  = '{SETA, 32'h0000_1003, 0, 0, 32'h0,          1'b0};
    vecs[1]  = '{WR,   32'hDEAD_BEEF, 3, 1, 32'h0000_1000,  1'b0};
    vecs[2]  = '{WR,   32'h0BAD_F00D, 0, 1, 32'h0000_1004,  1'b0};
    vecs[3]  = '{CTRL, 32'h0000_0001, 0, 0, 32'h0,          1'b0};
    vecs[4]  = '{CTRL, 32'h0000_0000, 0, 0, 32'h0,          1'b1};
    vecs[5]  = '{CTRL, 32'hFFFF_FFFE, 0, 0, 32'h0,          1'b1};
    vecs[6]  = '{CTRL, 32'h8000_0001, 0, 0, 32'h0,          1'b0};
    vecs[7]  = '{SETA, 32'hFFFF_FFFF, 0, 0, 32'h0,          1'b0};
    vecs[8]  = '{WR,   32'hA5A5_A5A5, 1, 1, 32'hFFFF_FFFC,  1'b0};
    vecs[9]  = '{WR,   32'h5A5A_5A5A, 0, 1, 32'h0000_0000,  1'b0};
    vecs[10] = '{CTRL, 32'h0000_0000, 0, 0, 32'h0,          1'b1};
    vecs[11] = '{WR,   32'h1357_9BDF, 2, 1, 32'h0000_0004,  1'b1};

    // Reset values.
    tick();
    tick();
    check("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_tx_dv", tx_dv, 1'b0);
    check("rst_tx_byte", tx_byte, 32'h0);
    check("rst_address", avm_address, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cpu_rst_n", cpu_rst_n, 1'b0);

    // Table-driven commands.
    foreach (vecs[i]) begin
      if (vecs[i].exp_wr)
        exp_bus.push_back('{0, vecs[i].exp_addr, vecs[i].payload, vecs[i].waits + 1});
      run_cmd(vecs[i].op, vecs[i].payload, vecs[i].waits);
      check($sformatf("vec%0d_cpu_rst_n", i), cpu_rst_n, vecs[i].exp_cpu);
    end
    check("table_no_overrun", overrun, 1'b0);

    // Three back-to-back writes while the first is stalled.
    run_cmd(SETA, 32'h0000_0300, 0);
    wr_before = wr_count;
    avm_waitrequest = 1'b1;
    exp_bus.push_back('{0, 32'h0000_0300, 32'h1111_1111, 0});
    exp_bus.push_back('{0, 32'h0000_0304, 32'h2222_2222, 0});
    send(WR, 32'h1111_1111);
    send(WR, 32'h2222_2222);
    check("pop_same_cycle_no_overrun", overrun, 1'b0);
    send(WR, 32'h3333_3333);
    check("third_write_overrun", overrun, 1'b1);
    tick();
    tick();
    avm_waitrequest = 1'b0;
    wait_bus("overrun_drain");
    for (int i = 0; i < 10; i++) tick();
    check("overrun_write_count", wr_count - wr_before, 2);
    check("overrun_sticky", overrun, 1'b1);

`ifdef UART_BRIDGE_READ_EN
    // Read with 2-cycle latency; next command must wait for tx_done.
    run_cmd(SETA, 32'h0000_0020, 0);
    exp_bus.push_back('{1, 32'h0000_0020, 32'h0, 1});
    exp_tx.push_back(32'h1234_5678);
    tx_before = tx_count;
    send(RD, 32'h0);
    wait_bus("read_accept");
    tick();
    tick();
    avm_readdata = 32'h1234_5678;
    avm_readdatavalid = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'hFFFF_FFFF;
    wr_before = wr_count;
    send(WR, 32'h0000_0077);
    for (int i = 0; i < 10; i++) tick();
    check("read_tx_pulses", tx_count - tx_before, 1);
    check("read_tx_queue", exp_tx.size(), 0);
    check("tx_byte_held", tx_byte, 32'h1234_5678);
    check("no_pop_before_done", wr_count - wr_before, 0);
    exp_bus.push_back('{0, 32'h0000_0024, 32'h0000_0077, 1});
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_bus("write_after_read");

    // Reset pulse during RD_WAIT; late readdatavalid must not reach TX.
    run_cmd(SETA, 32'h0000_0090, 0);
    exp_bus.push_back('{1, 32'h0000_0090, 32'h0, 1});
    send(RD, 32'h0);
    wait_bus("rdwait_accept");
    tick();
    tx_before = tx_count;
    #2;
    rst_n = 1'b0;
    #1;
    check("rdwait_rst_read", avm_read, 1'b0);
    check("rdwait_rst_tx_dv", tx_dv, 1'b0);
    check("rdwait_rst_addr", avm_address, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    avm_readdata = 32'hCAFE_0001;
    avm_readdatavalid = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("late_rdv_no_tx", tx_count - tx_before, 0);
`else
    // READ is consumed as a no-op: no bus read, no TX, addr unchanged.
    run_cmd(SETA, 32'h0000_0020, 0);
    send(RD, 32'h0);
    avm_readdata = 32'h1234_5678;
    avm_readdatavalid = 1'b1;
    tx_done = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    exp_bus.push_back('{0, 32'h0000_0020, 32'h0000_0077, 1});
    run_cmd(WR, 32'h0000_0077, 0);
    check("noread_rd_count", rd_count, 0);
    check("noread_tx_count", tx_count, 0);
    check("noread_tx_byte", tx_byte, 32'h0);
    tx_before = tx_count;
`endif

    // Reset pulse during a stalled write aborts it; addr restarts at 0.
    run_cmd(SETA, 32'h0000_0080, 0);
    wr_before = wr_count;
    avm_waitrequest = 1'b1;
    send(WR, 32'h0000_00AA);
    tick();
    tick();
    check("stalled_write_active", avm_write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("wr_rst_write", avm_write, 1'b0);
    check("wr_rst_addr", avm_address, 32'h0);
    check("wr_rst_overrun", overrun, 1'b0);
    check("wr_rst_cpu_rst_n", cpu_rst_n, 1'b0);
    avm_waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("aborted_write_gone", wr_count - wr_before, 0);
    exp_bus.push_back('{0, 32'h0000_0000, 32'h0000_00BB, 1});
    run_cmd(WR, 32'h0000_00BB, 0);
    check("final_tx_count", tx_count - tx_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_avalon_bridge.md
# uart_avalon_bridge

Command bridge sitting directly downstream of `uart_rx` and upstream of `uart_tx`. It consumes each 34-bit received word as a 2-bit opcode plus a 32-bit payload, and turns it into a single Avalon-MM master transaction on the system bus. This is how the host loads program memory, reads memory back and holds or releases the RISC-V core. Read results are returned to the host as 32-bit words through `uart_tx`.

## Interface
- Parameters:
  - `ADDR_W`, 32, Avalon address width.
  - `RST_HOLD`, 1, reset value of the core-hold flag (1 = core held in reset).
- Ports:
  - `i_Clock` in 1: system clock; the only clock in the block.
  - `i_Rst_n` in 1: reset, asynchronous assert, active-low.
  - `i_Rx_DV` in 1: one-cycle strobe from `uart_rx`; `i_Rx_Byte` is valid in that cycle.
  - `i_Rx_Byte` in 34: `[33:32]` opcode, `[31:0]` payload.
  - `o_Tx_DV` out 1: one-cycle start strobe to `uart_tx`.
  - `o_Tx_Byte` out 32: word to transmit; held stable until `i_Tx_Done`.
  - `i_Tx_Done` in 1: one-cycle pulse from `uart_tx` when its stop bit completes.
  - `avm_address` out ADDR_W: word-aligned byte address.
  - `avm_read` / `avm_write` out 1: Avalon read and write requests.
  - `avm_writedata` out 32: write data.
  - `avm_byteenable` out 4: always 4'hF.
  - `avm_waitrequest` in 1: slave stall.
  - `avm_readdata` in 32, `avm_readdatavalid` in 1: read response.
  - `o_Cpu_Rst_n` out 1: core reset, active-low.
  - `o_Overrun` out 1: sticky; a command was dropped.

## Operation
- Opcodes:
  - 2'b00 SET_ADDR: `addr <= payload & ~3`.
  - 2'b01 WRITE: Avalon write of payload to `addr`, then `addr += 4`.
  - 2'b10 READ: Avalon read of `addr`, send `readdata` through TX, then `addr += 4`.
  - 2'b11 CTRL: `o_Cpu_Rst_n <= ~payload[0]`; payload bits `[31:1]` are ignored.
- Command buffer:
  - One holding register (`pend_valid`, `pend_word`) captures `i_Rx_DV` in any state.
  - If `pend_valid` is already set when a new `i_Rx_DV` arrives, the new word is dropped and `o_Overrun` is set. It clears only on reset.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, TX_START, TX_WAIT.
  - IDLE with `pend_valid`: pop the buffer.
    - SET_ADDR and CTRL complete in IDLE, one cycle each.
    - WRITE goes to WR; READ goes to RD_REQ.
  - WR: `avm_write`=1 until a cycle with `avm_waitrequest`=0, then increment `addr` and go to IDLE.
  - RD_REQ: `avm_read`=1 until `avm_waitrequest`=0, then go to RD_WAIT.
  - RD_WAIT: on `avm_readdatavalid`, capture `avm_readdata` into `o_Tx_Byte` and go to TX_START.
  - TX_START: `o_Tx_DV`=1 for exactly one cycle, then go to TX_WAIT.
  - TX_WAIT: on `i_Tx_Done`, increment `addr` and go to IDLE.
- Address arithmetic: modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0. Bits `[1:0]` are always 0.
- `avm_address`/`avm_writedata` are stable while a request is asserted. `avm_read` and `avm_write` are never asserted together.
- Reset values:
  - State IDLE; `addr`=0.
  - All strobes 0.
  - `o_Tx_Byte`=0.
  - `o_Overrun`=0.
  - `o_Cpu_Rst_n`=~RST_HOLD.
  - `pend_valid`=0.
- Reset asserted mid-transaction aborts immediately. All outputs go to their reset values in the same instant (asynchronous).

## Timing
- Buffered command to bus request: `i_Rx_DV` at cycle N, buffer valid at N+1, FSM pops at N+1, request visible at N+2.
- Zero-wait write: `avm_write` high for 1 cycle; `addr` updates the cycle after.
- Read return: `o_Tx_DV` asserted 2 cycles after the `avm_readdatavalid` cycle.
- `i_Rx_DV` in the same cycle the FSM pops the buffer: accepted, no overrun.
- `i_Tx_Done` outside TX_WAIT: ignored.
- `avm_readdatavalid` outside RD_WAIT: ignored.

## Configuration
- `UART_BRIDGE_READ_EN` defined: READ works as specified.
- `UART_BRIDGE_READ_EN` undefined:
  - Opcode 2'b10 is consumed as a no-op; `addr` is unchanged.
  - `avm_read`, `o_Tx_DV` and `o_Tx_Byte` are tied to 0.
  - States RD_REQ, RD_WAIT, TX_START and TX_WAIT are not built.

## Structure
- Package `uart_bridge_pkg`:
  - opcode enum (`OP_SETADDR`, `OP_WRITE`, `OP_READ`, `OP_CTRL`).
  - FSM state enum.
  - `CMD_W`=34, `DATA_W`=32.
- No sub-module: buffer and FSM live in one module. `uart_rx` and `uart_tx` are instantiated alongside it by the parent, not inside it.

## Test plan
- SET_ADDR 0x0000_1003, then WRITE 0xDEAD_BEEF with `avm_waitrequest` high for 3 cycles:
  - one write to 0x0000_1000 of 0xDEAD_BEEF, held 4 cycles;
  - `addr` becomes 0x0000_1004.
- SET_ADDR 0x20, then READ; slave returns 0x1234_5678 after 2 cycles:
  - `o_Tx_DV` pulses once with `o_Tx_Byte`=0x1234_5678;
  - no further command is popped before `i_Tx_Done`.
- Three WRITE commands arrive back-to-back while the first write is stalled by `avm_waitrequest`:
  - the second is buffered;
  - the third is dropped and `o_Overrun`=1;
  - exactly two writes appear on the bus.
- CTRL 0x1 then CTRL 0x0:
  - `o_Cpu_Rst_n` goes 0, then 1;
  - out of reset it equals 0 with RST_HOLD=1.
- SET_ADDR 0xFFFF_FFFC then two WRITEs: addresses 0xFFFF_FFFC then 0x0000_0000.
- `i_Rst_n` pulsed low during RD_WAIT:
  - `avm_read`, `o_Tx_DV` and `addr` are 0 immediately;
  - a late `avm_readdatavalid` produces no TX.
